// File: rtl/cfg_reg_bank_pkg.sv
// Shared register indices and byte-lane merge helpers for the config register bank.
package cfg_reg_bank_pkg;

    localparam int unsigned REG_ID      = 0;
    localparam int unsigned REG_STATUS  = 1;
    localparam int unsigned REG_IRQ_EN  = 2;
    localparam int unsigned REG_RW_BASE = 3;
    localparam int unsigned BYTE_W      = 8;

    // Plain RW byte lane: take the write data when the lane is enabled.
    function automatic logic [BYTE_W-1:0] strb_merge(
        input logic [BYTE_W-1:0] cur,
        input logic [BYTE_W-1:0] wdat,
        input logic              en
    );
        return en ? wdat : cur;
    endfunction

    // W1C byte lane with hardware set; set is applied after the clear so it wins.
    function automatic logic [BYTE_W-1:0] w1c_merge(
        input logic [BYTE_W-1:0] cur,
        input logic [BYTE_W-1:0] clr,
        input logic              en,
        input logic [BYTE_W-1:0] set
    );
        return (cur & ~(en ? clr : BYTE_W'(0))) | set;
    endfunction

endpackage

// File: rtl/cfg_reg_bank.sv
// Config register bank: ID, W1C STATUS, IRQ_EN and general RW registers on a
// simple wr/rd register port with one-cycle read latency and a level irq.
module cfg_reg_bank
    import cfg_reg_bank_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned            NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0]  ID_VALUE   = DATA_WIDTH'(32'hC0F1_0001),
    parameter logic [DATA_WIDTH-1:0]  RW_RESET   = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic [STRB_WIDTH-1:0]                wstrb,
    input  logic                                 rd,
    input  logic [ADDR_WIDTH-1:0]                raddr,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 rvalid,
    input  logic [DATA_WIDTH-1:0]                status_set,
    output logic [(NUM_REGS-3)*DATA_WIDTH-1:0]   ctrl_q,
    output logic                                 irq
);

    localparam int unsigned NUM_RW   = NUM_REGS - REG_RW_BASE;
    localparam int unsigned OFF_BITS = $clog2(STRB_WIDTH);

    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [DATA_WIDTH-1:0] irq_en_q, irq_en_d;
    logic [DATA_WIDTH-1:0] rw_q [NUM_RW];
    logic [DATA_WIDTH-1:0] rw_d [NUM_RW];
    logic [DATA_WIDTH-1:0] rd_val;

    logic [ADDR_WIDTH-1:0] w_idx, r_idx;
    logic                  w_map, r_map;
    logic                  sel_status, sel_irq_en;

    // Word index decode; addresses below the base wrap high and are caught explicitly.
    assign w_idx = (waddr - BASE_ADDR) >> OFF_BITS;
    assign r_idx = (raddr - BASE_ADDR) >> OFF_BITS;
    assign w_map = (waddr >= BASE_ADDR) && (w_idx < ADDR_WIDTH'(NUM_REGS));
    assign r_map = (raddr >= BASE_ADDR) && (r_idx < ADDR_WIDTH'(NUM_REGS));

    assign sel_status = wr && w_map && (w_idx == ADDR_WIDTH'(REG_STATUS));
    assign sel_irq_en = wr && w_map && (w_idx == ADDR_WIDTH'(REG_IRQ_EN));

    // Next register contents from the write port and hardware status events.
    always_comb begin
        status_d = status_q;
        irq_en_d = irq_en_q;
        rw_d     = rw_q;
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            status_d[b*BYTE_W +: BYTE_W] = w1c_merge(status_q[b*BYTE_W +: BYTE_W],
                                                     wdata[b*BYTE_W +: BYTE_W],
                                                     sel_status && wstrb[b],
                                                     status_set[b*BYTE_W +: BYTE_W]);
            irq_en_d[b*BYTE_W +: BYTE_W] = strb_merge(irq_en_q[b*BYTE_W +: BYTE_W],
                                                      wdata[b*BYTE_W +: BYTE_W],
                                                      sel_irq_en && wstrb[b]);
        end
        for (int unsigned r = 0; r < NUM_RW; r++) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                rw_d[r][b*BYTE_W +: BYTE_W] = strb_merge(
                    rw_q[r][b*BYTE_W +: BYTE_W], wdata[b*BYTE_W +: BYTE_W],
                    wr && w_map && (w_idx == ADDR_WIDTH'(REG_RW_BASE + r)) && wstrb[b]);
            end
        end
    end

    // Read mux over current (pre-write) contents; unmapped reads return zero.
    always_comb begin
        rd_val = '0;
        if (r_map) begin
            if (r_idx == ADDR_WIDTH'(REG_ID)) begin
                rd_val = ID_VALUE;
            end else if (r_idx == ADDR_WIDTH'(REG_STATUS)) begin
                rd_val = status_q;
            end else if (r_idx == ADDR_WIDTH'(REG_IRQ_EN)) begin
                rd_val = irq_en_q;
            end
            for (int unsigned r = 0; r < NUM_RW; r++) begin
                if (r_idx == ADDR_WIDTH'(REG_RW_BASE + r)) begin
                    rd_val = rw_q[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            irq_en_q <= '0;
            for (int unsigned r = 0; r < NUM_RW; r++) begin
                rw_q[r] <= RW_RESET;
            end
            rdata    <= '0;
            rvalid   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            rw_q     <= rw_d;
            rvalid   <= rd;
            if (rd) begin
                rdata <= rd_val;
            end
            irq      <= |(status_q & irq_en_q);
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_q[g*DATA_WIDTH +: DATA_WIDTH] = rw_q[g];
    end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Self-checking bench for cfg_reg_bank: reference register model plus a read scoreboard.
module tb_cfg_reg_bank;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned NR  = 16;
    localparam int unsigned NRW = NR - 3;
    localparam int unsigned CW  = NRW * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          rd;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic [DW-1:0] status_set;
    logic [CW-1:0] ctrl_q;
    logic          irq;

    always #5 clk = ~clk;

    cfg_reg_bank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .NUM_REGS   (NR),
        .BASE_ADDR  (32'h0),
        .ID_VALUE   (32'hC0F1_0001),
        .RW_RESET   (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .waddr      (waddr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .rd         (rd),
        .raddr      (raddr),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .status_set (status_set),
        .ctrl_q     (ctrl_q),
        .irq        (irq)
    );

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    logic [DW-1:0] m_rw [NRW];
    logic [DW-1:0] m_status;
    logic [DW-1:0] m_en;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] lane_mask(input logic [SW-1:0] s);
        logic [DW-1:0] m;
        for (int b = 0; b < SW; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [AW-1:0] idx;
        idx = a >> 2;
        if (idx == 0) return 32'hC0F1_0001;
        if (idx == 1) return m_status;
        if (idx == 2) return m_en;
        if (idx < NR) return m_rw[idx-3];
        return '0;
    endfunction

    function automatic logic [CW-1:0] exp_ctrl();
        logic [CW-1:0] v;
        for (int r = 0; r < NRW; r++) v[r*DW +: DW] = m_rw[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NRW; r++) m_rw[r] = '0;
        m_status = '0;
        m_en     = '0;
    endtask

    // One bus cycle: expected read data is captured before the model applies the write.
    task automatic bus(input logic dw, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [SW-1:0] ws, input logic dr, input logic [AW-1:0] ra,
                       input logic [DW-1:0] ss);
        logic [AW-1:0] idx;
        logic [DW-1:0] m;
        exp_t          e;
        wr = dw; waddr = wa; wdata = wd; wstrb = ws;
        rd = dr; raddr = ra; status_set = ss;
        if (dr) begin
            e.data = model_read(ra);
            e.due  = cyc + 1;
            sb.push_back(e);
        end
        idx = wa >> 2;
        m   = lane_mask(ws);
        if (dw && idx == 1) m_status = m_status & ~(wd & m);
        if (dw && idx == 2) m_en = (m_en & ~m) | (wd & m);
        if (dw && idx >= 3 && idx < NR) m_rw[idx-3] = (m_rw[idx-3] & ~m) | (wd & m);
        m_status = m_status | ss;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; status_set = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Read scoreboard: every rvalid must match the oldest expectation in its due cycle.
    always @(negedge clk) begin
        if (rvalid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rvalid: got rdata=%h at cycle %0d, required no rvalid", rdata, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rdata !== e.data || cyc !== e.due) begin
                    n_err++;
                    $display("FAIL read_data: got rdata=%h at cycle %0d, required %h at cycle %0d",
                             rdata, cyc, e.data, e.due);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_rvalid: no rvalid at cycle %0d, required rdata=%h", cyc, e.data);
        end
    end

    task automatic test_reset();
        rst = 1'b1; wr = 1'b1; waddr = 32'hC; wdata = '1; wstrb = '1;
        rd = 1'b1; raddr = 32'h0; status_set = '1;
        idle(3);
        rst = 1'b0; wr = 1'b0; rd = 1'b0; status_set = '0; wstrb = '0;
        model_reset();
        idle(1);
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b, required 0", rvalid); end
        n_vec++; if (rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b, required 0", irq); end
        n_vec++; if (ctrl_q !== '0) begin n_err++; $display("FAIL reset_ctrl_q: got %h, required 0", ctrl_q); end
        bus(0, 0, 0, 0, 1, 32'h4, 0);
        bus(0, 0, 0, 0, 1, 32'h8, 0);
    endtask

    task automatic test_id();
        bus(0, 0, 0, 0, 1, 32'h0, 0);
        bus(1, 32'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        bus(0, 0, 0, 0, 1, 32'h0, 0);
        bus(0, 0, 0, 0, 1, 32'h2, 0);
    endtask

    task automatic test_strobe();
        logic [CW-1:0] snap;
        bus(1, 32'hC, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        n_vec++; if (ctrl_q[31:0] !== 32'h00BB_00DD) begin
            n_err++; $display("FAIL strobe_ctrl_q: got %h, required 00bb00dd", ctrl_q[31:0]);
        end
        bus(0, 0, 0, 0, 1, 32'hC, 0);
        snap = ctrl_q;
        bus(1, 32'h10, 32'h1234_5678, 4'b0000, 0, 0, 0);
        n_vec++; if (ctrl_q !== snap) begin
            n_err++; $display("FAIL zero_strobe: got %h, required %h", ctrl_q, snap);
        end
        bus(1, 32'h13, 32'h1234_5678, 4'b1100, 1, 32'h11, 0);
        n_vec++; if (ctrl_q !== exp_ctrl()) begin
            n_err++; $display("FAIL byte_offset_write: got %h, required %h", ctrl_q, exp_ctrl());
        end
        bus(0, 0, 0, 0, 1, 32'h10, 0);
    endtask

    task automatic test_status_irq();
        bus(1, 32'h8, 32'h1, 4'hF, 0, 0, 0);
        bus(0, 0, 0, 0, 0, 0, 32'h5);
        idle(1);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_assert: got %b, required 1", irq); end
        bus(1, 32'h4, 32'h1, 4'hF, 0, 0, 0);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_lag: got %b, required 1", irq); end
        bus(0, 0, 0, 0, 1, 32'h4, 0);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b, required 0", irq); end
        bus(1, 32'h4, 32'h4, 4'h0, 1, 32'h8, 0);
        bus(0, 0, 0, 0, 1, 32'h4, 0);
    endtask

    task automatic test_set_wins();
        bus(1, 32'h4, 32'h1, 4'h1, 0, 0, 32'h1);
        bus(0, 0, 0, 0, 1, 32'h4, 0);
        n_vec++; if (m_status[0] !== 1'b1) begin
            n_err++; $display("FAIL set_wins_model: got %b, required 1", m_status[0]);
        end
        bus(1, 32'h4, 32'h5, 4'hF, 1, 32'h4, 0);
        bus(0, 0, 0, 0, 1, 32'h4, 0);
    endtask

    task automatic test_unmapped();
        logic [CW-1:0] snap;
        bus(0, 0, 0, 0, 1, 32'h40, 0);
        bus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        snap = ctrl_q;
        bus(1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        bus(1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 1, 32'h4, 0);
        n_vec++; if (ctrl_q !== snap) begin
            n_err++; $display("FAIL unmapped_write: got %h, required %h", ctrl_q, snap);
        end
        bus(0, 0, 0, 0, 1, 32'h8, 0);
        bus(1, 32'h3C, 32'h1234_5678, 4'hF, 0, 0, 0);
        n_vec++; if (ctrl_q[CW-1 -: DW] !== 32'h1234_5678) begin
            n_err++; $display("FAIL last_reg_write: got %h, required 12345678", ctrl_q[CW-1 -: DW]);
        end
        bus(0, 0, 0, 0, 1, 32'h3C, 0);
    endtask

    task automatic test_back_to_back();
        bus(0, 0, 0, 0, 1, 32'h0, 0);
        bus(0, 0, 0, 0, 1, 32'hC, 0);
        bus(0, 0, 0, 0, 1, 32'h4, 0);
        bus(1, 32'hC, 32'h1122_3344, 4'hF, 1, 32'hC, 0);
        bus(0, 0, 0, 0, 1, 32'hC, 0);
        for (int i = 0; i < 60; i++) begin
            bus(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
                $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
                $urandom & $urandom & $urandom);
        end
        n_vec++; if (ctrl_q !== exp_ctrl()) begin
            n_err++; $display("FAIL random_ctrl_q: got %h, required %h", ctrl_q, exp_ctrl());
        end
        idle(2);
        n_vec++; if (irq !== |(m_status & m_en)) begin
            n_err++; $display("FAIL random_irq: got %b, required %b", irq, |(m_status & m_en));
        end
    endtask

    task automatic test_rst_drop();
        bus(0, 0, 0, 0, 1, 32'hC, 0);
        rst = 1'b1; rd = 1'b1; raddr = 32'h0; wr = 1'b1; waddr = 32'hC;
        wdata = '1; wstrb = '1; status_set = '1;
        @(posedge clk); #1;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; status_set = '0;
        model_reset();
        n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rst_drop_rvalid: got %b, required 0", rvalid); end
        n_vec++; if (rdata !== '0) begin n_err++; $display("FAIL rst_drop_rdata: got %h, required 0", rdata); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_drop_irq: got %b, required 0", irq); end
        n_vec++; if (ctrl_q !== '0) begin n_err++; $display("FAIL rst_drop_ctrl_q: got %h, required 0", ctrl_q); end
        idle(3);
        bus(0, 0, 0, 0, 1, 32'h4, 0);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
        rd = 1'b0; raddr = '0; status_set = '0;
        model_reset();
        test_reset();
        test_id();
        test_strobe();
        test_status_irq();
        test_set_wins();
        test_unmapped();
        test_back_to_back();
        test_rst_drop();
        idle(3);
        n_vec++; if (sb.size() != 0) begin
            n_err++; $display("FAIL pending_reads: got %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_reg_bank.md
CFG_REG_BANK -- requirements
Module: cfg_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the register-port address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the register width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, the byte-strobe width.
REQ-004 SHALL have parameter NUM_REGS, default 16, the number of word registers (minimum 4).
REQ-005 SHALL have parameter BASE_ADDR, default 0, the byte address of register 0.
REQ-006 SHALL have parameter ID_VALUE, default 32'hC0F1_0001, the read-only ID register contents.
REQ-007 SHALL have parameter RW_RESET, default 0, the reset value of every general RW register.
REQ-008 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-009 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-010 SHALL have port wr, input, 1, a single-cycle write strobe.
REQ-011 SHALL have port waddr, input, ADDR_WIDTH, the write byte address.
REQ-012 SHALL have port wdata, input, DATA_WIDTH, the write data.
REQ-013 SHALL have port wstrb, input, STRB_WIDTH, the write byte enables.
REQ-014 SHALL have port rd, input, 1, a single-cycle read strobe.
REQ-015 SHALL have port raddr, input, ADDR_WIDTH, the read byte address.
REQ-016 SHALL have port rdata, output, DATA_WIDTH, the read data.
REQ-017 SHALL have port rvalid, output, 1, read data valid; one pulse per rd.
REQ-018 SHALL have port status_set, input, DATA_WIDTH, per-bit hardware event pulses into STATUS.
REQ-019 SHALL have port ctrl_q, output, (NUM_REGS-3)*DATA_WIDTH, general RW registers flattened, register 3 in the LSBs.
REQ-020 SHALL have port irq, output, 1, the level interrupt.

Function
REQ-021 SHALL compute the word index as (addr - BASE_ADDR) >> log2(STRB_WIDTH), ignoring the low byte-offset bits.
REQ-022 SHALL treat an index >= NUM_REGS, or an addr < BASE_ADDR, as unmapped.
REQ-023 SHALL map index 0 as ID: read-only, returns ID_VALUE, writes ignored.
REQ-024 SHALL map index 1 as STATUS: W1C per byte lane under wstrb; bits set by status_set.
REQ-025 SHALL map index 2 as IRQ_EN: RW per byte lane.
REQ-026 SHALL map indices 3..NUM_REGS-1 as general RW per byte lane, driven continuously on ctrl_q.
REQ-027 SHALL update a written register on the clk edge where wr=1, visible on ctrl_q the next cycle.
REQ-028 SHALL, when a status_set bit and a W1C of the same bit occur in the same cycle, leave the bit set (set wins).
REQ-029 SHALL assert rvalid exactly one cycle after rd=1 (latency 1), with rdata valid in that cycle.
REQ-030 SHALL hold rdata until the next read; rvalid is high only for a single cycle per rd.
REQ-031 SHALL accept back-to-back reads, rd on consecutive cycles, giving rvalid on consecutive cycles.
REQ-032 SHALL return 0 in rdata, with rvalid still asserted, for a read of an unmapped address.
REQ-033 SHALL ignore writes to unmapped addresses with no side effect.
REQ-034 SHALL, for rd and wr in the same cycle to the same register, return the pre-write value.
REQ-035 SHALL perform no write when wstrb is all zero, including no W1C.
REQ-036 SHALL register irq = |(STATUS & IRQ_EN); irq follows the STATUS/IRQ_EN update by one cycle.
REQ-037 SHALL tolerate rd and wr together every cycle with no stall; the block has no backpressure.

Reset
REQ-038 SHALL, while rst=1, set STATUS=0, IRQ_EN=0, every RW register=RW_RESET, rdata=0, rvalid=0 and irq=0.
REQ-039 SHALL, with rst asserted during an outstanding read, drop the read; no rvalid after rst.
REQ-040 SHALL ignore status_set, wr and rd during any cycle with rst=1.

Structure
REQ-041 SHALL put the index localparams REG_ID=0, REG_STATUS=1, REG_IRQ_EN=2, REG_RW_BASE=3 in the shared package cfg_reg_bank_pkg.
REQ-042 SHALL put the byte-strobe merge function and the W1C merge function in cfg_reg_bank_pkg.
REQ-043 SHALL implement the block as a single module with no sub-modules.
REQ-044 SHALL be able to connect directly to the register port of the AXI config bridge: wr, waddr, wdata, wstrb, rd, raddr, rdata and rvalid.

Verification
REQ-045 SHALL cover: rd raddr=0x0 -> rvalid and rdata=0xC0F10001 on the next cycle; then wr 0x0 with 0xFFFFFFFF, then rd -> rdata is still 0xC0F10001.
REQ-046 SHALL cover: wr 0xC, wdata 0xAABBCCDD, wstrb 0b0101, from reset -> rd 0xC returns 0x00BB00DD; ctrl_q[31:0]=0x00BB00DD.
REQ-047 SHALL cover: status_set=0x5 pulse, IRQ_EN=0x1 -> irq=1; wr 0x4 with 0x1 -> STATUS=0x4 and irq=0 one cycle later.
REQ-048 SHALL cover: status_set bit0 together with W1C of bit0 in the same cycle -> STATUS bit0 stays 1.
REQ-049 SHALL cover: rd 0x40 with NUM_REGS=16 -> rvalid=1 and rdata=0; wr 0x40 -> no register changes.
REQ-050 SHALL cover: rd on 3 consecutive cycles to 0x0, 0xC, 0x4 -> 3 consecutive rvalid pulses with matching data; rst on the cycle after an rd -> no rvalid.
